// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running h/v counters advanced by a pixel-step enable,
// with registered sync, data-enable, look-ahead data-enable, coordinates and line/frame strobes.
module video_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1,
  parameter int LOOKAHEAD = 0,
  parameter int CW        = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          de_early,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // All position arithmetic is one bit wider than the counters so h+LOOKAHEAD cannot wrap.
  localparam logic [CW:0] HT       = (CW+1)'(H_TOTAL);
  localparam logic [CW:0] H_LAST   = (CW+1)'(H_TOTAL - 1);
  localparam logic [CW:0] V_LAST   = (CW+1)'(V_TOTAL - 1);
  localparam logic [CW:0] HA       = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] VA       = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] HS_START = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] HS_END   = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] VS_START = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] VS_END   = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW:0] LA       = (CW+1)'(LOOKAHEAD);

  logic [CW-1:0] r_h;
  logic [CW-1:0] r_v;

  logic [CW:0] w_h;
  logic [CW:0] w_v;
  logic        w_h_last;
  logic        w_v_last;
  logic [CW:0] w_hl_sum;
  logic        w_hl_wrap;
  logic [CW:0] w_hl;
  logic [CW:0] w_vl;
  logic        w_de;
  logic        w_de_early;
  logic        w_hs_act;
  logic        w_vs_act;

  assign w_h      = {1'b0, r_h};
  assign w_v      = {1'b0, r_v};
  assign w_h_last = (w_h == H_LAST);
  assign w_v_last = (w_v == V_LAST);

  // LOOKAHEAD never exceeds the blanking interval, so the look-ahead point crosses at most one line.
  assign w_hl_sum  = w_h + LA;
  assign w_hl_wrap = (w_hl_sum >= HT);
  assign w_hl      = w_hl_wrap ? (w_hl_sum - HT) : w_hl_sum;
  assign w_vl      = !w_hl_wrap ? w_v : (w_v_last ? '0 : (w_v + 1'b1));

  assign w_de       = (w_h < HA) && (w_v < VA);
  assign w_de_early = (w_hl < HA) && (w_vl < VA);
  assign w_hs_act   = (w_h >= HS_START) && (w_h < HS_END);
  assign w_vs_act   = (w_v >= VS_START) && (w_v < VS_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h         <= '0;
      r_v         <= '0;
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      de_early    <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (ce) begin
        r_h <= w_h_last ? '0 : (r_h + 1'b1);
        if (w_h_last) begin
          r_v <= w_v_last ? '0 : (r_v + 1'b1);
        end
        x           <= r_h;
        y           <= r_v;
        de          <= w_de;
        de_early    <= w_de_early;
        hsync       <= ~(w_hs_act ^ HS_POL);
        vsync       <= ~(w_vs_act ^ VS_POL);
        line_start  <= (r_h == '0);
        frame_start <= (r_h == '0) && (r_v == '0);
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized bench for video_timing_gen: a frame-position model (single step index p)
// predicts every output each clock under random ce/rst patterns.
module tb_video_timing_gen;

  localparam int H_ACTIVE  = 8;
  localparam int H_FP      = 2;
  localparam int H_SYNC    = 3;
  localparam int H_BP      = 2;
  localparam int V_ACTIVE  = 4;
  localparam int V_FP      = 1;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 1;
  localparam bit HS_POL    = 1'b0;
  localparam bit VS_POL    = 1'b1;
  localparam int LOOKAHEAD = 3;
  localparam int CW        = 4;
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME     = H_TOTAL * V_TOTAL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ce  = 1'b0;
  logic          hsync, vsync, de, de_early, line_start, frame_start;
  logic [CW-1:0] x, y;

  video_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .LOOKAHEAD(LOOKAHEAD), .CW(CW)
  ) u_dut (
    .clk(clk), .rst(rst), .ce(ce),
    .hsync(hsync), .vsync(vsync), .de(de), .de_early(de_early),
    .x(x), .y(y), .line_start(line_start), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model state: p is the frame step index of the internal counter.
  int p = 0;
  int e_x = 0, e_y = 0, e_de = 0, e_dee = 0, e_hs = 0, e_vs = 0, e_ls = 0, e_fs = 0;

  function automatic int de_at(input int pos);
    int hh = pos % H_TOTAL;
    int vv = pos / H_TOTAL;
    return ((hh < H_ACTIVE) && (vv < V_ACTIVE)) ? 1 : 0;
  endfunction

  task automatic model_step(input logic r, input logic c);
    int hh, vv;
    e_ls = 0;
    e_fs = 0;
    if (r) begin
      p = 0; e_x = 0; e_y = 0; e_de = 0; e_dee = 0;
      e_hs = HS_POL ? 0 : 1;
      e_vs = VS_POL ? 0 : 1;
    end else if (c) begin
      hh = p % H_TOTAL;
      vv = p / H_TOTAL;
      e_x   = hh;
      e_y   = vv;
      e_de  = de_at(p);
      e_dee = de_at((p + LOOKAHEAD) % FRAME);
      e_hs  = ((hh >= H_ACTIVE + H_FP) && (hh < H_ACTIVE + H_FP + H_SYNC)) == HS_POL ? 1 : 0;
      e_vs  = ((vv >= V_ACTIVE + V_FP) && (vv < V_ACTIVE + V_FP + V_SYNC)) == VS_POL ? 1 : 0;
      e_ls  = (hh == 0) ? 1 : 0;
      e_fs  = (p == 0) ? 1 : 0;
      p = (p + 1) % FRAME;
    end
  endtask

  task automatic cycle(input logic r, input logic c);
    rst = r;
    ce  = c;
    @(posedge clk);
    model_step(r, c);
    #1;
    chk_val("x", int'(x), e_x);
    chk_val("y", int'(y), e_y);
    chk_val("de", int'(de), e_de);
    chk_val("de_early", int'(de_early), e_dee);
    chk_val("hsync", int'(hsync), e_hs);
    chk_val("vsync", int'(vsync), e_vs);
    chk_val("line_start", int'(line_start), e_ls);
    chk_val("frame_start", int'(frame_start), e_fs);
  endtask

  initial begin
    // reset with ce toggling: reset must win
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'(i[0]));
    // ce constant high for two frames plus
    for (int i = 0; i < 2 * FRAME + 17; i++) cycle(1'b0, 1'b1);
    // mid-frame reset, then restart
    cycle(1'b1, 1'b1);
    for (int i = 0; i < FRAME + 5; i++) cycle(1'b0, 1'b1);
    // ce every 4th clock
    for (int i = 0; i < 4 * FRAME + 9; i++) cycle(1'b0, (i % 4) == 3);
    // fully random ce with rare reset pulses
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 399) == 0), 1'($urandom_range(0, 1)));
    end
    // reset held while ce idle, then release
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    for (int i = 0; i < FRAME; i++) cycle(1'b0, 1'($urandom_range(0, 2) != 0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
